// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types, widths and helpers for the ALU reservation station.
// Entry field widths are all derived from the typedefs below.
package rs_alu_scheduler_pkg;

    localparam int RS_SIZE  = 16;
    localparam int ROB_W    = 4;
    localparam int DATA_W   = 32;
    localparam int OP_W     = 6;
    localparam int ADDR_W   = 32;
    localparam int RS_IDX_W = $clog2(RS_SIZE);

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [ROB_W-1:0]  rob_index_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   openum_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam openum_t OP_ADD  = openum_t'(0);
    localparam openum_t OP_SUB  = openum_t'(1);
    localparam openum_t OP_OR   = openum_t'(2);
    localparam openum_t OP_ADDI = openum_t'(8);
    localparam openum_t OP_BEQ  = openum_t'(16);
    localparam openum_t OP_JAL  = openum_t'(24);

    typedef struct packed {
        data_t      val;
        rob_index_t dep;
    } operand_t;

    typedef struct packed {
        openum_t    op;
        rob_index_t rob;
        addr_t      pc;
        data_t      imm;
        logic       pred_br;
        operand_t   rs1;
        operand_t   rs2;
    } rs_entry_t;

    // ALU bus has priority when both buses carry the awaited tag.
    function automatic operand_t wake_operand(
        input operand_t   opnd,
        input logic       alu_v,
        input rob_index_t alu_i,
        input data_t      alu_r,
        input logic       lsb_v,
        input rob_index_t lsb_i,
        input data_t      lsb_r
    );
        operand_t res;
        res = opnd;
        if (opnd.dep != '0) begin
            if (alu_v && alu_i == opnd.dep) begin
                res.val = alu_r;
                res.dep = '0;
            end else if (lsb_v && lsb_i == opnd.dep) begin
                res.val = lsb_r;
                res.dep = '0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_alu_scheduler_if.sv
// Issue, broadcast and dispatch signals of the ALU reservation station.
// slave = the scheduler, master = the decoder/ALU/LSB side.
interface rs_alu_scheduler_if;
    import rs_alu_scheduler_pkg::*;

    logic       issue_ready;
    logic       issue_rs_ready;
    rob_index_t issue_rob_index;
    openum_t    issue_op;
    addr_t      issue_PC;
    data_t      issue_imm;
    logic       issue_pred_br;
    data_t      issue_rs1_val;
    data_t      issue_rs2_val;
    rob_index_t issue_rs1_depend;
    rob_index_t issue_rs2_depend;

    logic       alu_ready;
    rob_index_t alu_rob_index;
    data_t      alu_result;
    logic       lsb_ready;
    rob_index_t lsb_rob_index;
    data_t      lsb_result;

    logic       rs_full;
    logic       exe_valid;
    rob_index_t exe_rob_index;
    openum_t    exe_op;
    data_t      exe_rs1_val;
    data_t      exe_rs2_val;
    data_t      exe_imm;
    addr_t      exe_PC;
    logic       exe_pred_br;

    modport slave (
        input  issue_ready, issue_rs_ready, issue_rob_index, issue_op, issue_PC,
               issue_imm, issue_pred_br, issue_rs1_val, issue_rs2_val,
               issue_rs1_depend, issue_rs2_depend,
               alu_ready, alu_rob_index, alu_result,
               lsb_ready, lsb_rob_index, lsb_result,
        output rs_full, exe_valid, exe_rob_index, exe_op, exe_rs1_val,
               exe_rs2_val, exe_imm, exe_PC, exe_pred_br
    );

    modport master (
        output issue_ready, issue_rs_ready, issue_rob_index, issue_op, issue_PC,
               issue_imm, issue_pred_br, issue_rs1_val, issue_rs2_val,
               issue_rs1_depend, issue_rs2_depend,
               alu_ready, alu_rob_index, alu_result,
               lsb_ready, lsb_rob_index, lsb_result,
        input  rs_full, exe_valid, exe_rob_index, exe_op, exe_rs1_val,
               exe_rs2_val, exe_imm, exe_PC, exe_pred_br
    );

endinterface

// File: rtl/rs_alu_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module rs_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: buffers issued ops, wakes operands from the ALU/LSB
// buses and dispatches the lowest-index ready entry each cycle.
module rs_alu_scheduler
    import rs_alu_scheduler_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clr_in,
    rs_alu_scheduler_if.slave   sched_if
);

    localparam int CNT_W = RS_IDX_W + 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];

    logic       exe_valid_q, exe_valid_d;
    rob_index_t exe_rob_q, exe_rob_d;
    openum_t    exe_op_q, exe_op_d;
    data_t      exe_rs1_q, exe_rs1_d;
    data_t      exe_rs2_q, exe_rs2_d;
    data_t      exe_imm_q, exe_imm_d;
    addr_t      exe_pc_q, exe_pc_d;
    logic       exe_pred_q, exe_pred_d;

    logic [RS_SIZE-1:0]  free_vec, ready_vec;
    logic                free_found, ready_found;
    logic [RS_IDX_W-1:0] free_idx, ready_idx;
    logic [CNT_W-1:0]    free_cnt;
    logic                issue_fire;

    always_comb begin
        free_vec  = ~busy_q;
        ready_vec = '0;
        free_cnt  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i] && (ent_q[i].rs1.dep == '0) && (ent_q[i].rs2.dep == '0);
            free_cnt     = free_cnt + CNT_W'(!busy_q[i]);
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
        .req_i   (free_vec),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_enc (
        .req_i   (ready_vec),
        .found_o (ready_found),
        .idx_o   (ready_idx)
    );

    assign issue_fire = sched_if.issue_ready && sched_if.issue_rs_ready;

    // Free and ready vectors both come from registered state, so a slot freed
    // by this cycle's dispatch is never the allocation target in the same cycle.
    always_comb begin
        busy_d      = busy_q;
        ent_d       = ent_q;
        exe_valid_d = FALSE;
        exe_rob_d   = exe_rob_q;
        exe_op_d    = exe_op_q;
        exe_rs1_d   = exe_rs1_q;
        exe_rs2_d   = exe_rs2_q;
        exe_imm_d   = exe_imm_q;
        exe_pc_d    = exe_pc_q;
        exe_pred_d  = exe_pred_q;
        if (rdy_in) begin
            if (clr_in) begin
                busy_d = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        ent_d[i].rs1 = wake_operand(ent_q[i].rs1,
                            sched_if.alu_ready, sched_if.alu_rob_index, sched_if.alu_result,
                            sched_if.lsb_ready, sched_if.lsb_rob_index, sched_if.lsb_result);
                        ent_d[i].rs2 = wake_operand(ent_q[i].rs2,
                            sched_if.alu_ready, sched_if.alu_rob_index, sched_if.alu_result,
                            sched_if.lsb_ready, sched_if.lsb_rob_index, sched_if.lsb_result);
                    end
                end
                if (ready_found) begin
                    exe_valid_d       = TRUE;
                    exe_rob_d         = ent_q[ready_idx].rob;
                    exe_op_d          = ent_q[ready_idx].op;
                    exe_rs1_d         = ent_q[ready_idx].rs1.val;
                    exe_rs2_d         = ent_q[ready_idx].rs2.val;
                    exe_imm_d         = ent_q[ready_idx].imm;
                    exe_pc_d          = ent_q[ready_idx].pc;
                    exe_pred_d        = ent_q[ready_idx].pred_br;
                    busy_d[ready_idx] = FALSE;
                end
                if (issue_fire && free_found) begin
                    busy_d[free_idx]          = TRUE;
                    ent_d[free_idx].op        = sched_if.issue_op;
                    ent_d[free_idx].rob       = sched_if.issue_rob_index;
                    ent_d[free_idx].pc        = sched_if.issue_PC;
                    ent_d[free_idx].imm       = sched_if.issue_imm;
                    ent_d[free_idx].pred_br   = sched_if.issue_pred_br;
                    ent_d[free_idx].rs1.val   = sched_if.issue_rs1_val;
                    ent_d[free_idx].rs1.dep   = sched_if.issue_rs1_depend;
                    ent_d[free_idx].rs2.val   = sched_if.issue_rs2_val;
                    ent_d[free_idx].rs2.dep   = sched_if.issue_rs2_depend;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            exe_valid_q <= FALSE;
            exe_rob_q   <= '0;
            exe_op_q    <= '0;
            exe_rs1_q   <= '0;
            exe_rs2_q   <= '0;
            exe_imm_q   <= '0;
            exe_pc_q    <= '0;
            exe_pred_q  <= FALSE;
        end else begin
            busy_q      <= busy_d;
            exe_valid_q <= exe_valid_d;
            exe_rob_q   <= exe_rob_d;
            exe_op_q    <= exe_op_d;
            exe_rs1_q   <= exe_rs1_d;
            exe_rs2_q   <= exe_rs2_d;
            exe_imm_q   <= exe_imm_d;
            exe_pc_q    <= exe_pc_d;
            exe_pred_q  <= exe_pred_d;
        end
    end

    // Payload is only meaningful under busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        ent_q <= ent_d;
    end

    // An issue with no free slot is dropped; the decoder must honour rs_full.
    assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !clr_in && issue_fire && !free_found));

    assign sched_if.rs_full       = (free_cnt <= CNT_W'(1));
    assign sched_if.exe_valid     = exe_valid_q;
    assign sched_if.exe_rob_index = exe_rob_q;
    assign sched_if.exe_op        = exe_op_q;
    assign sched_if.exe_rs1_val   = exe_rs1_q;
    assign sched_if.exe_rs2_val   = exe_rs2_q;
    assign sched_if.exe_imm       = exe_imm_q;
    assign sched_if.exe_PC        = exe_pc_q;
    assign sched_if.exe_pred_br   = exe_pred_q;

endmodule

// File: doc/rs_alu_scheduler.md
# rs_alu_scheduler

Reservation-station scheduler for the ALU. Sits between the decoder's issue port and the single-cycle ALU: buffers issued arithmetic/branch/jump ops, wakes pending operands from the ALU and LSB result buses, and dispatches the lowest-index ready entry to the ALU each cycle. Also generates the `rs_full` back-pressure that feeds the decoder stall.

## Interface
- `RS_SIZE`, 16, entry count (power of two)
- `ROB_W`, 4, ROB index width; index 0 reserved as "no dependency"
- `DATA_W`, 32, operand/result width
- `OP_W`, 6, op-enum width
- `clk_in` in 1: the single clock
- `rst_in` in 1: asynchronous, active-high reset
- `rdy_in` in 1: global enable; low freezes all state
- `clr_in` in 1: synchronous flush (mispredict)
- `issue_ready` in 1: decoder issue strobe, qualified by `issue_rs_ready`
- `issue_rs_ready` in 1: op targets this station
- `issue_rob_index` in ROB_W; `issue_op` in OP_W; `issue_PC` in 32; `issue_imm` in DATA_W; `issue_pred_br` in 1
- `issue_rs1_val`, `issue_rs2_val` in DATA_W; `issue_rs1_depend`, `issue_rs2_depend` in ROB_W (0 = value valid)
- `alu_ready` in 1, `alu_rob_index` in ROB_W, `alu_result` in DATA_W: ALU broadcast
- `lsb_ready` in 1, `lsb_rob_index` in ROB_W, `lsb_result` in DATA_W: LSB broadcast
- `rs_full` out 1: fewer than 2 free entries
- `exe_valid` out 1: dispatch strobe, one cycle per op
- `exe_rob_index` out ROB_W; `exe_op` out OP_W; `exe_rs1_val`, `exe_rs2_val`, `exe_imm` out DATA_W; `exe_PC` out 32; `exe_pred_br` out 1

## Operation
- Per entry: `busy`, op, rob index, PC, imm, pred_br, two {val, depend}.
- Allocate: when `issue_ready && issue_rs_ready`, write the lowest-index free entry. The free vector is taken from current state; a slot freed by this cycle's dispatch is not reused until next cycle.
- Issue with zero free entries is a protocol violation. Drop it and fire a bench assertion.
- Wakeup: for each busy entry and each operand with depend != 0: if `alu_ready && alu_rob_index == depend`, capture `alu_result`; else if `lsb_ready` matches, capture `lsb_result`. Then clear depend.
  - Both operands of one entry may wake in the same cycle, from different buses.
  - The incoming issue is not wakeup-checked; the decoder already forwards same-cycle broadcasts.
- Select: ready = busy && both depends 0. Pick the lowest-index ready entry and register its fields onto `exe_*` with `exe_valid`=1, then clear its busy. No ready entry gives `exe_valid`=0; `exe_*` hold their last values.
- `rs_full` = (free count ≤ 1), combinational from registered busy bits. The margin covers the one-cycle decode-to-issue path.
- `clr_in` (with `rdy_in`): all busy cleared, `exe_valid` 0 next cycle, same-cycle issue and wakeup ignored.
- `rdy_in` low: no allocate, wakeup, dispatch or flush. `exe_valid` registers 0.
- Reset: all busy 0, `exe_valid` 0, all `exe_*` 0, so `rs_full` is 0.

## Timing
- Issue at cycle t with both depends 0: entry written at end of t, selected in t+1, `exe_valid` high in t+2.
- Broadcast at cycle k matching a pending operand: captured at end of k, `exe_valid` in k+2 at earliest.
- Dispatch throughput: 1 op/cycle; ALU accepts unconditionally.
- `rs_full` reflects allocation/dispatch one cycle after the edge that changed busy.
- Reset mid-operation: asynchronous, so outputs reach reset values immediately and all entries are lost.

## Structure
- Shared defines header holds: `ROB_INDEX_TYPE`, `DATA_TYPE`, `OPENUM_TYPE`, `ADDR_TYPE`, `RS_SIZE`, `TRUE`/`FALSE`. Entry field widths come from these.
- One sub-module, `rs_prio_enc`: RS_SIZE-bit lowest-set-bit encoder with `found` flag. It is instantiated twice, for free-slot and ready-slot selection.

## Test plan
- Reset, then issue ADDI rob=3, both depends 0 at cycle 1 → `exe_valid` in cycle 3 with `exe_rob_index`=3 and operands intact; `rs_full`=0 throughout.
- Issue ADD rob=5 with rs1_depend=2. In cycle 4, `alu_ready` rob=2 result 0x1234 → `exe_valid` in cycle 6 with `exe_rs1_val`=0x1234.
- Entry waiting on rob 2 (rs1) and rob 7 (rs2). Same cycle: ALU broadcasts 2=0xA and LSB broadcasts 7=0xB → dispatch 2 cycles later with 0xA/0xB.
- Fill 15 entries, all dependent → `rs_full`=1. Wake entry 0 → it dispatches, and `rs_full` drops the cycle after busy clears.
- Three ready entries in slots 1, 4, 9 → dispatched in order 1, 4, 9 on consecutive cycles.
- 10 busy entries, then assert `clr_in` together with an issue → next cycle `exe_valid`=0, no entries busy, and the issued op is absent. Repeat with `rdy_in` low for 3 cycles → state frozen, then resumes.
